mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/mdu_div_step.sv | 22 ++
 rtl/mult_div_unit.sv | 105 ++++++++++
 tb/tb_mult_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types (word, ALU and multiply/divide opcodes).
package cpu_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } aluop_t;

    // Codes 6 and 7 are undefined and must be ignored by the multiply/divide unit.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mduop_t;

    function automatic logic mdu_op_valid(input mduop_t op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division step; shifts in the next dividend bit and subtracts the divisor if it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_part = {i_rem, i_bit};
        w_diff = w_part - {1'b0, i_div};
        o_q    = w_part >= {1'b0, i_div};
        o_rem  = o_q ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit, one bit per cycle, with a final sign-fixup cycle.
module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  mduop_t           op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_div, r_neg_q, r_neg_r, r_bz, r_dz;
    logic [WIDTH-1:0] r_ah, r_al, r_b, r_hi, r_lo;

    logic             w_accept, w_signed, w_div, w_mt, w_qbit;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem, w_res_hi, w_res_lo;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod;

    // r_ah/r_al hold the running product (upper/lower) or the partial remainder/quotient.
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_ah),
        .i_bit (r_al[WIDTH-1]),
        .i_div (r_b),
        .o_rem (w_rem),
        .o_q   (w_qbit)
    );

    always_comb begin
        w_signed = (op == MDU_MULT) || (op == MDU_DIV);
        w_div    = (op == MDU_DIV) || (op == MDU_DIVU);
        w_mt     = (op == MDU_MTHI) || (op == MDU_MTLO);
        w_accept = start && (r_state == IDLE || r_state == DONE) && mdu_op_valid(op);
        w_abs_a  = (w_signed && A[WIDTH-1]) ? -A : A;
        w_abs_b  = (w_signed && B[WIDTH-1]) ? -B : B;
        w_next   = (r_state == CALC) ? ((r_cnt == CW'(1)) ? SIGN : CALC) :
                   (r_state == SIGN) ? DONE :
                   w_accept ? (w_mt ? DONE : CALC) : IDLE;
        w_sum    = {1'b0, r_ah} + (r_al[0] ? {1'b0, r_b} : '0);
        w_prod   = r_neg_q ? -{r_ah, r_al} : {r_ah, r_al};
        w_res_hi = r_div ? (r_neg_r ? -r_ah : r_ah) : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = r_div ? (r_bz ? '1 : (r_neg_q ? -r_al : r_al)) : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bz    <= 1'b0;
            r_dz    <= 1'b0;
            r_ah    <= '0;
            r_al    <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_dz    <= 1'b0;
                r_div   <= w_div;
                r_neg_q <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                r_neg_r <= w_signed && A[WIDTH-1];
                r_bz    <= (B == '0);
                r_ah    <= '0;
                r_al    <= w_abs_a;
                r_b     <= w_abs_b;
                r_cnt   <= CW'(WIDTH);
                if (op == MDU_MTHI) r_hi <= A;
                if (op == MDU_MTLO) r_lo <= A;
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt - CW'(1);
                r_ah  <= r_div ? w_rem : w_sum[WIDTH:1];
                r_al  <= r_div ? {r_al[WIDTH-2:0], w_qbit} : {w_sum[0], r_al[WIDTH-1:1]};
            end else if (r_state == SIGN) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
                r_dz <= r_div && r_bz;
            end
        end
    end

    assign busy = (r_state == CALC) || (r_state == SIGN);
    assign done = (r_state == DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of 32-bit and 8-bit mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic s32 = 1'b0, s8 = 1'b0;
    mduop_t op32 = MDU_MULT, op8 = MDU_MULT;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic busy32, done32, dz32, busy8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0] hi8, lo8;

    mult_div_unit #(.WIDTH(32)) u32 (
        .CLK(clk), .RST(rst), .start(s32), .op(op32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .dz(dz32)
    );

    mult_div_unit #(.WIDTH(8)) u8 (
        .CLK(clk), .RST(rst), .start(s8), .op(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dz(dz8)
    );

    bit sel8 = 1'b0;
    logic [31:0] o_hi, o_lo;
    logic o_busy, o_done, o_dz;
    assign o_hi   = sel8 ? {24'h0, hi8} : hi32;
    assign o_lo   = sel8 ? {24'h0, lo8} : lo32;
    assign o_busy = sel8 ? busy8 : busy32;
    assign o_done = sel8 ? done8 : done32;
    assign o_dz   = sel8 ? dz8 : dz32;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];
    logic        m_dz [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result computed with plain signed/unsigned arithmetic.
    task automatic model(input int w, input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, inout logic dz);
        longint mask, sa, sb, p, q, r;
        longint unsigned up;
        mask = (longint'(1) << w) - 1;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        dz = 1'b0;
        case (op)
            MDU_MULT: begin
                p = sa * sb;
                hi = 32'((p >>> w) & mask);
                lo = 32'(p & mask);
            end
            MDU_MULTU: begin
                up = 64'(a) * 64'(b);
                hi = 32'(up >> w);
                lo = 32'(up & 64'(mask));
            end
            MDU_DIV, MDU_DIVU: begin
                if (b == 0) begin
                    dz = 1'b1;
                    lo = 32'(mask);
                    hi = a;
                end else if (op == MDU_DIVU) begin
                    lo = a / b;
                    hi = a % b;
                end else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                    lo = a;
                    hi = 0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = 32'(q & mask);
                    hi = 32'(r & mask);
                end
            end
            MDU_MTHI: hi = a;
            MDU_MTLO: lo = a;
            default: ;
        endcase
    endtask

    // Caller is at a negedge; start is driven immediately so it can land in a DONE cycle.
    task automatic run(input bit w8, input mduop_t op, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at);
        int w, idx, lat, busy_cyc, extra;
        bit iter, held;
        logic [31:0] eh, el, h0, l0;
        logic ed;
        w = w8 ? 8 : 32;
        idx = w8 ? 1 : 0;
        iter = (op <= MDU_DIVU);
        sel8 = w8;
        eh = m_hi[idx];
        el = m_lo[idx];
        ed = m_dz[idx];
        model(w, op, a, b, eh, el, ed);
        #1;
        h0 = o_hi;
        l0 = o_lo;
        if (w8) begin s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else begin s32 = 1'b1; op32 = op; a32 = a; b32 = b; end
        @(posedge clk);
        @(negedge clk);
        s8 = 1'b0;
        s32 = 1'b0;
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        op32 = mduop_t'($urandom_range(0, 5));
        op8 = mduop_t'($urandom_range(0, 5));
        lat = 1;
        busy_cyc = 0;
        held = 1'b1;
        while (!o_done && lat < w + 8) begin
            if (o_busy) busy_cyc++;
            if (o_hi !== h0 || o_lo !== l0) held = 1'b0;
            if (lat == poke_at) begin
                if (w8) begin s8 = 1'b1; op8 = MDU_MTHI; end
                else begin s32 = 1'b1; op32 = MDU_MTHI; end
            end else begin
                s8 = 1'b0;
                s32 = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        s8 = 1'b0;
        s32 = 1'b0;
        check($sformatf("latency op%0d w%0d", op, w), 64'(lat), iter ? 64'(w + 2) : 64'd1);
        check($sformatf("busy_cycles op%0d", op), 64'(busy_cyc), iter ? 64'(w + 1) : 64'd0);
        if (iter) check("hold_hi_lo", 64'(held), 64'd1);
        check($sformatf("hi op%0d a=%0h b=%0h", op, a, b), 64'(o_hi), 64'(eh));
        check($sformatf("lo op%0d a=%0h b=%0h", op, a, b), 64'(o_lo), 64'(el));
        check($sformatf("dz op%0d", op), 64'(o_dz), 64'(ed));
        m_hi[idx] = eh;
        m_lo[idx] = el;
        m_dz[idx] = ed;
        if (poke_at > 0) begin
            extra = 0;
            repeat (w + 4) begin
                @(posedge clk);
                @(negedge clk);
                if (o_done) extra++;
            end
            check("ignored_start_extra_done", 64'(extra), 64'd0);
            check("dz_held", 64'(o_dz), 64'(ed));
        end
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 0;
            1: v = 1;
            2: v = '1;
            3: v = 32'h1 << (w - 1);
            default: v = $urandom;
        endcase
        return (w == 8) ? {24'h0, v[7:0]} : v;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin m_hi[i] = 0; m_lo[i] = 0; m_dz[i] = 0; end
        @(negedge clk);
        check("reset_busy", 64'(busy32), 64'd0);
        check("reset_done", 64'(done32), 64'd0);
        check("reset_hi_lo", {hi32, lo32}, 64'd0);
        check("reset_dz", 64'(dz32), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run(0, MDU_MULT, 32'hFFFFFFFD, 32'd7, 0);
        run(0, MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run(0, MDU_DIV, 32'hFFFFFFF9, 32'd2, 0);
        run(0, MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        run(0, MDU_DIVU, 32'd10, 32'd0, 10);
        run(0, MDU_MTHI, 32'hCAFEF00D, 32'd0, 0);

        s32 = 1'b1;
        op32 = mduop_t'(3'd6);
        @(posedge clk);
        @(negedge clk);
        s32 = 1'b0;
        check("undef_op_done", 64'(done32), 64'd0);
        check("undef_op_busy", 64'(busy32), 64'd0);
        check("undef_op_hi_lo", {hi32, lo32}, {m_hi[0], m_lo[0]});
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            run(0, mduop_t'($urandom_range(0, 5)), pick(32), pick(32), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        run(0, MDU_MTHI, 32'hDEADBEEF, 32'd0, 0);
        run(0, MDU_MTLO, 32'h12345678, 32'd0, 0);
        s32 = 1'b1;
        op32 = MDU_DIVU;
        a32 = 32'd100;
        b32 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        s32 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy32), 64'd0);
        check("async_rst_hi_lo", {hi32, lo32}, 64'd0);
        check("async_rst_done_dz", {done32, dz32}, 64'd0);
        for (int i = 0; i < 2; i++) begin m_hi[i] = 0; m_lo[i] = 0; m_dz[i] = 0; end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, MDU_MTLO, 32'h00001234, 32'd0, 0);
        @(posedge clk);
        @(negedge clk);
        check("mtlo_done_one_cycle", 64'(done32), 64'd0);

        @(negedge clk);
        run(1, MDU_MULTU, 32'hFF, 32'hFF, 0);
        run(1, MDU_DIVU, 32'h64, 32'h07, 0);
        @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            run(1, mduop_t'($urandom_range(0, 5)), pick(8), pick(8), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
